// File: rtl/div32_seq.sv
// Iterative radix-2 restoring divider with signed/unsigned mode and a start/busy/done handshake.
// One quotient bit per clock; sign correction and divide-by-zero results are applied in a final FIX cycle.
module div32_seq #(
  parameter int WIDTH   = 32,
  parameter bit DZ_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_q, q_q, dv, a_raw;
  logic             sign_q, sign_r, dz;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, r_nx;
  logic             ge, b_zero, unused_r_msb;

  assign a_abs  = (mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_abs  = (mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign b_zero = (b == '0);

  // Partial remainder stays below the divisor, so the restored value always fits WIDTH bits.
  assign shifted      = {r_q, q_q[WIDTH-1]};
  assign ge           = (shifted >= {1'b0, dv});
  assign r_nx         = ge ? (shifted - {1'b0, dv}) : shifted;
  assign unused_r_msb = r_nx[WIDTH];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (DZ_FAST && b_zero) ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      dv     <= '0;
      a_raw  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      quo    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          r_q    <= '0;
          q_q    <= a_abs;
          dv     <= b_abs;
          a_raw  <= a;
          sign_q <= mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          sign_r <= mode & a[WIDTH-1];
          dz     <= b_zero;
          cnt    <= CW'(WIDTH);
          busy   <= 1'b1;
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          q_q <= {q_q[WIDTH-2:0], ge};
          r_q <= r_nx[WIDTH-1:0];
        end
        FIX: begin
          // Divide-by-zero overrides the core result even when it ran the full length.
          quo  <= dz ? '1    : (sign_q ? (~q_q + 1'b1) : q_q);
          rem  <= dz ? a_raw : (sign_r ? (~r_q + 1'b1) : r_q);
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div32_seq.sv
// Directed and randomized checks of div32_seq against a plain-arithmetic division model.
module tb_div32_seq;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] quo, rem;
  int checks = 0, failures = 0, csv_n = 0;

  div32_seq #(.WIDTH(32), .DZ_FAST(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .quo(quo), .rem(rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V DIV/DIVU/REM/REMU semantics; 64-bit signed math covers the overflow case.
  function automatic void model(input bit m, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r);
    longint sx, sy;
    if (y == 32'd0) begin
      q = '1;
      r = x;
    end else if (m) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = 32'(sx / sy);
      r  = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  task automatic issue(input bit m, input logic [31:0] x, input logic [31:0] y);
    mode  = m;
    a     = x;
    b     = y;
    start = 1'b1;
  endtask

  // Called with start already raised; returns #1 after the done edge (the done cycle).
  task automatic finish_op(input string tag, input bit m, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eq, er;
    int n;
    model(m, x, y, eq, er);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"},  {31'd0, done}, 32'd1);
    check({tag, "_lat"},   32'(n), (y == 32'd0) ? 32'd1 : 32'd33);
    check({tag, "_quo"},   quo, eq);
    check({tag, "_rem"},   rem, er);
    check({tag, "_nbusy"}, {31'd0, busy}, 32'd0);
    if (csv_n < 6) begin
      $display("csv,%0d,%h,%h,%h/%h,%h/%h,%0d", m, x, y, eq, er, quo, rem,
               (quo === eq) && (rem === er));
      csv_n++;
    end
  endtask

  initial begin
    logic [31:0] x, y;
    int n;
    bit saw_done;

    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quo", quo, 32'd0);
    check("rst_rem", rem, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    issue(0, 32'd6785, 32'd292);
    finish_op("t1", 0, 32'd6785, 32'd292);
    check("t1_q_lit", quo, 32'd23);
    check("t1_r_lit", rem, 32'd69);
    @(posedge clk); #1;
    check("t1_pulse", {31'd0, done}, 32'd0);

    issue(0, 32'h8FA4B672, 32'h6C3F8132);
    finish_op("t2", 0, 32'h8FA4B672, 32'h6C3F8132);
    check("t2_r_lit", rem, 32'h23653540);
    @(negedge clk);
    issue(1, 32'hFFFFFFF9, 32'd2);
    finish_op("t3a", 1, 32'hFFFFFFF9, 32'd2);
    check("t3a_q_lit", quo, 32'hFFFFFFFD);
    issue(1, 32'd7, 32'hFFFFFFFE);
    finish_op("t3b", 1, 32'd7, 32'hFFFFFFFE);
    check("t3b_r_lit", rem, 32'd1);
    issue(0, 32'h1234, 32'd0);
    finish_op("t4u", 0, 32'h1234, 32'd0);
    issue(1, 32'h1234, 32'd0);
    finish_op("t4s", 1, 32'h1234, 32'd0);
    check("t4s_r_lit", rem, 32'h1234);
    issue(1, 32'h80000000, 32'hFFFFFFFF);
    finish_op("t4ov", 1, 32'h80000000, 32'hFFFFFFFF);
    check("t4ov_q_lit", quo, 32'h80000000);

    // Second start while busy must be ignored.
    @(negedge clk);
    issue(0, 32'd100, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(1, 32'd999, 32'd3);
    @(posedge clk); #1;
    start = 1'b0;
    n = 5;
    while (!done && n < 45) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_lat", 32'(n), 32'd33);
    check("t5_quo", quo, 32'd14);
    check("t5_rem", rem, 32'd2);

    // Reset in the middle of an operation.
    @(negedge clk);
    issue(1, 32'hFFFFFC18, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5r_busy", {31'd0, busy}, 32'd0);
    check("t5r_done", {31'd0, done}, 32'd0);
    check("t5r_quo", quo, 32'd0);
    check("t5r_rem", rem, 32'd0);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("t5r_nodone", {31'd0, saw_done}, 32'd0);
    issue(1, 32'hFFFFFC18, 32'd7);
    finish_op("t5n", 1, 32'hFFFFFC18, 32'd7);
    check("t5n_q_lit", quo, 32'hFFFFFF72);

    // Random back-to-back operations in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 300; i++) begin
        x = $urandom;
        case ($urandom_range(0, 7))
          0: y = 32'($urandom_range(1, 20));
          1: y = -32'($urandom_range(1, 20));
          2: y = 32'd0;
          3: begin x = 32'h80000000; y = $urandom; end
          default: y = $urandom >> $urandom_range(0, 31);
        endcase
        issue(m[0], x, y);
        finish_op("rnd", m[0], x, y);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
